// File: rtl/issue_sched_pkg.sv
// sched_pkg: shared types and defaults for the issue scheduler.
//   fu_e            - functional-unit code carried on req_fu_i
//   TAG_W           - physical destination tag width
//   DEF_NUM_ENTRIES - default reservation-station entry count
//   DEF_MUL_LAT     - default multiplier latency (issue to CDB)
//   NUM_FU          - number of arbitrated FUs (ALU, MUL, LSU)
package sched_pkg;

  typedef enum logic [1:0] {
    FU_ALU  = 2'd0,
    FU_MUL  = 2'd1,
    FU_LSU  = 2'd2,
    FU_NONE = 2'd3
  } fu_e;

  localparam int TAG_W           = 5;
  localparam int DEF_NUM_ENTRIES = 4;
  localparam int DEF_MUL_LAT     = 3;
  localparam int NUM_FU          = 3;

endpackage

// File: rtl/issue_sched_if.sv
// issue_sched_if: request/grant and CDB bundle of the issue scheduler.
//   master - reservation station / LSU side (drives requests, readies, flush)
//   slave  - scheduler side (drives grants, CDB, mul_busy)
interface issue_sched_if #(
  parameter int NUM_ENTRIES = sched_pkg::DEF_NUM_ENTRIES
);
  localparam int TW = sched_pkg::TAG_W;

  logic [NUM_ENTRIES-1:0]         req_valid_i;
  logic [NUM_ENTRIES-1:0][1:0]    req_fu_i;
  logic [NUM_ENTRIES-1:0][TW-1:0] req_tag_i;
  logic                           alu_ready_i;
  logic                           lsu_ready_i;
  logic                           lsu_wb_req_i;
  logic [TW-1:0]                  lsu_wb_tag_i;
  logic                           flush_i;

  logic [NUM_ENTRIES-1:0]         alu_gnt_o;
  logic [NUM_ENTRIES-1:0]         mul_gnt_o;
  logic [NUM_ENTRIES-1:0]         lsu_gnt_o;
  logic                           lsu_wb_gnt_o;
  logic                           cdb_en_o;
  logic [TW-1:0]                  cdb_tag_o;
  logic                           mul_busy_o;

  modport master (
    output req_valid_i, req_fu_i, req_tag_i, alu_ready_i, lsu_ready_i,
           lsu_wb_req_i, lsu_wb_tag_i, flush_i,
    input  alu_gnt_o, mul_gnt_o, lsu_gnt_o, lsu_wb_gnt_o, cdb_en_o,
           cdb_tag_o, mul_busy_o
  );

  modport slave (
    input  req_valid_i, req_fu_i, req_tag_i, alu_ready_i, lsu_ready_i,
           lsu_wb_req_i, lsu_wb_tag_i, flush_i,
    output alu_gnt_o, mul_gnt_o, lsu_gnt_o, lsu_wb_gnt_o, cdb_en_o,
           cdb_tag_o, mul_busy_o
  );

endinterface

// File: rtl/issue_sched_rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter with internal pointer.
//   clk_i, reset_ni - clock, synchronous active-low reset
//   req             - request vector
//   en              - grant enable; when low no grant and pointer holds
//   gnt             - one-hot-or-zero grant (combinational)
// The search starts at the pointer; after a grant the pointer moves to
// the slot just past the winner so it gets lowest priority next time.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] nxt;
  logic [IDX_W-1:0] idx;
  logic             hit;

  always_comb begin
    gnt = '0;
    hit = 1'b0;
    nxt = ptr;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDX_W'((int'(ptr) + k) % N);
      if (!hit && en && req[idx]) begin
        gnt[idx] = 1'b1;
        hit      = 1'b1;
        nxt      = IDX_W'((int'(ptr) + k + 1) % N);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni)  ptr <= '0;
    else if (hit)   ptr <= nxt;
  end

endmodule

// File: rtl/issue_sched.sv
// issue_sched: per-FU round-robin issue arbitration plus CDB arbitration.
//   clk_i, reset_ni - clock, synchronous active-low reset
//   bus (slave)     - per-entry requests (valid/fu/tag), ALU/LSU ready,
//                     LSU writeback request, flush; per-FU one-hot grants,
//                     LSU writeback grant, CDB enable/tag, multiplier busy
// ALU results broadcast the cycle after issue; the multiplier broadcasts
// MUL_LAT cycles after issue. ALU issue is held off in the one cycle whose
// ALU broadcast would collide with the multiplier's, so the CDB only ever
// arbitrates between one fixed-latency result and the LSU.
module issue_sched import sched_pkg::*; #(
  parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
  parameter int MUL_LAT     = DEF_MUL_LAT
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  issue_sched_if.slave  bus
);

  localparam int CNT_W = ($clog2(MUL_LAT + 1) < 2) ? 2 : $clog2(MUL_LAT + 1);

  logic [NUM_FU-1:0][NUM_ENTRIES-1:0] fu_req;
  logic [NUM_FU-1:0][NUM_ENTRIES-1:0] fu_gnt;
  logic [NUM_FU-1:0]                  fu_en;

  logic [CNT_W-1:0] mul_cnt;
  logic [TAG_W-1:0] mul_tag;
  logic [TAG_W-1:0] alu_tag;
  logic             alu_pend;

  logic [TAG_W-1:0] mul_tag_in;
  logic [TAG_W-1:0] alu_tag_in;
  logic             go;
  logic             mul_issue;
  logic             alu_issue;
  logic             alu_conflict;
  logic             mul_done;
  logic             alu_out;
  logic             lsu_win;

  // Nothing issues or broadcasts from the pipeline during reset or flush.
  assign go = reset_ni && !bus.flush_i;

  // One arbiter per FU; an entry only requests the FU its code names, so
  // code 3 (FU_NONE) never reaches any arbiter.
  for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
    for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_ent
      assign fu_req[f][e] = bus.req_valid_i[e] && (bus.req_fu_i[e] == 2'(f));
    end
    rr_arbiter #(.N(NUM_ENTRIES)) u_arb (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .req      (fu_req[f]),
      .en       (fu_en[f]),
      .gnt      (fu_gnt[f])
    );
  end

  assign mul_issue = |fu_gnt[FU_MUL];
  assign alu_issue = |fu_gnt[FU_ALU];

  // Counter at 2 means the multiplier broadcasts next cycle, which is when
  // an ALU issued now would also broadcast. With a 1-cycle multiplier the
  // collision is with a MUL issued in the same cycle instead.
  assign alu_conflict = (int'(mul_cnt) == 2) || ((MUL_LAT == 1) && mul_issue);

  assign fu_en[FU_ALU] = go && bus.alu_ready_i && !alu_conflict;
  assign fu_en[FU_MUL] = go && (mul_cnt == '0);
  assign fu_en[FU_LSU] = go && bus.lsu_ready_i;

  // Grants are one-hot, so OR-ing the masked tags selects the winner's tag.
  always_comb begin
    mul_tag_in = '0;
    alu_tag_in = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      if (fu_gnt[FU_MUL][e]) mul_tag_in = mul_tag_in | bus.req_tag_i[e];
      if (fu_gnt[FU_ALU][e]) alu_tag_in = alu_tag_in | bus.req_tag_i[e];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      mul_cnt  <= '0;
      mul_tag  <= '0;
      alu_tag  <= '0;
      alu_pend <= 1'b0;
    end else if (bus.flush_i) begin
      mul_cnt  <= '0;
      alu_pend <= 1'b0;
    end else begin
      if (mul_issue) begin
        mul_cnt <= CNT_W'(MUL_LAT);
        mul_tag <= mul_tag_in;
      end else if (mul_cnt != '0) begin
        mul_cnt <= mul_cnt - CNT_W'(1);
      end
      alu_pend <= alu_issue;
      if (alu_issue) alu_tag <= alu_tag_in;
    end
  end

  // CDB: MUL completion > pending ALU > LSU writeback. A flush kills the
  // in-flight pipeline results but the LSU may still write back.
  assign mul_done = go && (mul_cnt == CNT_W'(1));
  assign alu_out  = go && alu_pend;
  assign lsu_win  = reset_ni && bus.lsu_wb_req_i && !mul_done && !alu_out;

  always_comb begin
    bus.cdb_en_o  = 1'b0;
    bus.cdb_tag_o = '0;
    if (mul_done) begin
      bus.cdb_en_o  = 1'b1;
      bus.cdb_tag_o = mul_tag;
    end else if (alu_out) begin
      bus.cdb_en_o  = 1'b1;
      bus.cdb_tag_o = alu_tag;
    end else if (lsu_win) begin
      bus.cdb_en_o  = 1'b1;
      bus.cdb_tag_o = bus.lsu_wb_tag_i;
    end
  end

  assign bus.alu_gnt_o    = fu_gnt[FU_ALU];
  assign bus.mul_gnt_o    = fu_gnt[FU_MUL];
  assign bus.lsu_gnt_o    = fu_gnt[FU_LSU];
  assign bus.lsu_wb_gnt_o = lsu_win;
  assign bus.mul_busy_o   = reset_ni && (mul_cnt != '0);

endmodule

// File: doc/issue_sched.md
ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4, number of reservation-station entries arbitrated.
REQ-002 SHALL have parameter MUL_LAT, default 3, multiplier latency in cycles (issue to CDB broadcast).
REQ-003 SHALL have ports: clk_i in 1 clock; reset_ni in 1 reset. One clock; reset is synchronous and active-low.
REQ-004 SHALL have ports: req_valid_i in NUM_ENTRIES per-entry ready-to-issue; req_fu_i in 2*NUM_ENTRIES per-entry FU type (0 ALU, 1 MUL, 2 LSU, 3 reserved/ignored); req_tag_i in 5*NUM_ENTRIES per-entry prd tag.
REQ-005 SHALL have ports: alu_ready_i in 1 ALU can accept; lsu_ready_i in 1 LSU can accept; lsu_wb_req_i in 1 LSU result pending; lsu_wb_tag_i in 5 its tag; flush_i in 1 pipeline flush.
REQ-006 SHALL have ports: alu_gnt_o, mul_gnt_o, lsu_gnt_o out NUM_ENTRIES each, one-hot-or-zero issue grants; lsu_wb_gnt_o out 1; cdb_en_o out 1; cdb_tag_o out 5; mul_busy_o out 1.

Function
REQ-007 SHALL compute grants combinationally in the same cycle as req_valid_i; an entry SHALL be granted only by the FU matching its req_fu_i.
REQ-008 SHALL pick among eligible entries per FU by round-robin from that FU's pointer; pointer SHALL advance to (granted index + 1) mod NUM_ENTRIES only on a grant, else hold.
REQ-009 ALU grant SHALL require alu_ready_i=1 and no CDB conflict (REQ-012); at most one ALU grant per cycle.
REQ-010 MUL grant SHALL require the multiplier idle (counter = 0); a grant loads the counter with MUL_LAT and latches the tag; counter decrements each cycle; mul_busy_o = (counter != 0).
REQ-011 LSU grant SHALL require lsu_ready_i=1; LSU issue never reserves the CDB.
REQ-012 ALU issue in cycle t broadcasts in t+1; ALU grant SHALL be suppressed in cycle t if the multiplier counter equals 2 (MUL broadcast due in t+1).
REQ-013 CDB priority each cycle: MUL completing (counter = 1) > ALU issued previous cycle > LSU (lsu_wb_req_i); cdb_en_o=1 and cdb_tag_o = winner's tag; otherwise cdb_en_o=0, cdb_tag_o=0.
REQ-014 lsu_wb_gnt_o SHALL be 1 exactly when LSU wins the CDB; LSU SHALL hold lsu_wb_req_i until granted.
REQ-015 flush_i=1 SHALL force all grants to 0 that cycle, clear the multiplier counter and the ALU-pending flag next edge; cdb_en_o SHALL be 0 in the flush cycle except for an LSU writeback; RR pointers hold.
REQ-016 Simultaneous MUL completion and ALU-pending SHALL not occur (guaranteed by REQ-012); simultaneous grants to different FUs in one cycle SHALL be allowed.
REQ-017 Entries with req_fu_i=3 SHALL never be granted.

Reset
REQ-018 On reset_ni=0 at a clock edge: RR pointers = 0, multiplier counter = 0, MUL/ALU tag registers = 0, ALU-pending = 0.
REQ-019 While reset_ni=0, all grant outputs, lsu_wb_gnt_o, cdb_en_o, mul_busy_o SHALL be 0 and cdb_tag_o = 0; reset mid-multiply SHALL discard the operation without broadcast.

Structure
REQ-020 Package sched_pkg SHALL hold fu_e enum (FU_ALU, FU_MUL, FU_LSU, FU_NONE), TAG_W=5, default NUM_ENTRIES and MUL_LAT.
REQ-021 A sub-module rr_arbiter (NUM_ENTRIES-way, request vector + enable in, one-hot grant out, internal pointer) SHALL be instantiated once per FU.

Verification
REQ-022 Entries 0,1,2 request ALU every cycle, alu_ready_i=1 -> alu_gnt_o 0001,0010,0100,0001; cdb_tag_o follows one cycle later.
REQ-023 Entry 3 requests MUL tag 9 at t0 -> mul_gnt_o=1000 at t0, mul_busy_o=1 t0+1..t0+3, cdb_en_o=1 cdb_tag_o=9 at t0+3; second MUL request granted no earlier than t0+3.
REQ-024 MUL granted t0, entry 0 ALU request at t0+2 -> alu_gnt_o=0 at t0+2, granted t0+3, broadcast t0+4.
REQ-025 lsu_wb_req_i=1 tag 17 in a cycle with ALU pending -> lsu_wb_gnt_o=0, ALU tag on CDB; next idle cycle lsu_wb_gnt_o=1, cdb_tag_o=17.
REQ-026 flush_i=1 at t0+1 after MUL grant at t0 -> no MUL broadcast, mul_busy_o=0 from t0+2; reset_ni=0 mid-multiply likewise, all outputs 0.
